// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the LSQ-side data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;
    localparam int LINES       = 16;
    localparam int MEM_LATENCY = 10;
    localparam int INDEX_W     = 4;
    localparam int TAG_W       = 5;

    localparam logic SIZE_HALF = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;
endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Direct-mapped valid/tag/data storage, one halfword per line.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import mem_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [15:0]        rd_data,
    input  logic               wr_en,
    input  logic               wr_fill,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [1:0]         wr_be,
    input  logic [15:0]        wr_data
);
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES];

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: a cleared valid bit hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill)  tag_q[wr_index]        <= wr_tag;
            if (wr_be[1]) data_q[wr_index][15:8] <= wr_data[15:8];
            if (wr_be[0]) data_q[wr_index][7:0]  <= wr_data[7:0];
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];
endmodule
`default_nettype wire

// File: rtl/mem_hierarchy.sv
`default_nettype none
// ============================================================================
// Module      : mem_hierarchy
// Description : Blocking write-through data cache between the LSQ and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_hierarchy
    import mem_pkg::*;
#(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic        req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [5:0]  req_tag,
    input  logic        flush,
    output logic        resp_valid,
    output logic [5:0]  resp_tag,
    output logic [31:0] resp_data,
    output logic [31:0] dm_address,
    output logic [31:0] dm_dataSw,
    output logic        dm_memRead,
    output logic        dm_memWrite,
    output logic        dm_storeSize,
    output logic        dm_cacheMiss,
    output logic        dm_fromLSQ,
    input  logic [31:0] dm_lwData
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               store_q, store_d;
    logic               size_q, size_d;
    logic [5:0]         rtag_q, rtag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        cap_q, cap_d;
    logic               killed_q, killed_d;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [15:0]        rd_data;
    logic               wr_en, wr_fill;
    logic [1:0]         wr_be;
    logic [15:0]        wr_data;
    logic               line_match, load_hit;
    logic               unused_dm_hi;

    assign unused_dm_hi = ^dm_lwData[31:16];
    assign dm_fromLSQ   = 1'b0;

    // Odd addresses share the index of their even partner, so one lookup serves both.
    assign line_match = rd_valid && (rd_tag == addr_q[9:5]);
    assign load_hit   = !store_q && !addr_q[0] && line_match;

    dcache_array #(.LINES(LINES)) u_array (
        .clk      (clk),
        .clear    (rst),
        .rd_index (addr_q[4:1]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_fill  (wr_fill),
        .wr_index (addr_q[4:1]),
        .wr_tag   (addr_q[9:5]),
        .wr_be    (wr_be),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        size_d       = size_q;
        rtag_d       = rtag_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        killed_d     = killed_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_tag     = '0;
        resp_data    = '0;
        dm_address   = '0;
        dm_dataSw    = '0;
        dm_memRead   = 1'b0;
        dm_memWrite  = 1'b0;
        dm_storeSize = 1'b0;
        dm_cacheMiss = 1'b0;
        wr_en        = 1'b0;
        wr_fill      = 1'b0;
        wr_be        = 2'b00;
        wr_data      = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !flush) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    store_d  = req_is_store;
                    size_d   = req_size;
                    rtag_d   = req_tag;
                    killed_d = 1'b0;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (store_q) begin
                    dm_address   = addr_q;
                    dm_dataSw    = wdata_q;
                    dm_memWrite  = 1'b1;
                    dm_storeSize = size_q;
                    dm_cacheMiss = 1'b1;
                    resp_valid   = 1'b1;
                    resp_tag     = rtag_q;
                    // Odd-address halfwords straddle two lines and are left to memory only.
                    wr_en = line_match && !(size_q == SIZE_HALF && addr_q[0]);
                    if (size_q == SIZE_HALF) begin
                        wr_be   = 2'b11;
                        wr_data = wdata_q[15:0];
                    end else if (!addr_q[0]) begin
                        wr_be   = 2'b10;
                        wr_data = {wdata_q[7:0], 8'h00};
                    end else begin
                        wr_be   = 2'b01;
                        wr_data = {8'h00, wdata_q[7:0]};
                    end
                    state_d = ST_IDLE;
                end else if (load_hit) begin
                    resp_valid = 1'b1;
                    resp_tag   = rtag_q;
                    resp_data  = {16'h0000, rd_data};
                    state_d    = ST_IDLE;
                end else begin
                    dm_address   = addr_q;
                    dm_memRead   = 1'b1;
                    dm_cacheMiss = 1'b1;
                    cnt_d        = CNT_W'(1);
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) killed_d = 1'b1;
                if (cnt_q == CNT_W'(MEM_LATENCY)) begin
                    cap_d   = dm_lwData[15:0];
                    cnt_d   = '0;
                    wr_en   = !addr_q[0];
                    wr_fill = 1'b1;
                    wr_be   = 2'b11;
                    wr_data = dm_lwData[15:0];
                    state_d = (killed_q || flush) ? ST_IDLE : ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_tag   = rtag_q;
                resp_data  = {16'h0000, cap_q};
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            size_q   <= 1'b0;
            rtag_q   <= '0;
            cnt_q    <= '0;
            cap_q    <= '0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            size_q   <= size_d;
            rtag_q   <= rtag_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            killed_q <= killed_d;
        end
    end
endmodule
`default_nettype wire
